// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: byte-lane register block, small TX FIFO,
// baud-divided shifter and a level interrupt raised when the transmitter drains.
module uart_tx_port #(
   parameter logic [15:0] BASEADDR    = 16'h0018,
   parameter int          FIFODEPTH   = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dwrite_addr,
   input  logic [15:0] dwrite_data,
   input  logic [1:0]  dwrite_en,
   input  logic [15:0] dread_addr,
   output logic [15:0] dread_data,
   output logic        txd,
   output logic        interrupt
);

   localparam int PW = $clog2(FIFODEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFODEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   tx_state_t     state;
   logic [15:0]   div;
   logic [15:0]   cnt;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;

   logic [7:0]    mem [FIFODEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic          irq_en;

   logic          full, empty, busy, pop, push, push_ok;
   logic [7:0]    push_byte;
   logic          ctrl_we;
   logic [7:0]    ctrl_byte;
   logic          div_lo_we, div_hi_we;
   logic [7:0]    div_lo_byte, div_hi_byte;

   logic [15:0]   w0_off, w1_off;
   logic          w0_hit, w1_hit;

   assign w0_off = dwrite_addr - BASEADDR;
   assign w1_off = dwrite_addr + 16'd1 - BASEADDR;
   assign w0_hit = dwrite_en[0] && (w0_off < 16'd4);
   assign w1_hit = dwrite_en[1] && (w1_off < 16'd4);

   // Each lane decodes independently; the two lanes can never hit the same offset.
   always_comb begin
      div_lo_we   = 1'b0;
      div_hi_we   = 1'b0;
      push        = 1'b0;
      ctrl_we     = 1'b0;
      div_lo_byte = '0;
      div_hi_byte = '0;
      push_byte   = '0;
      ctrl_byte   = '0;
      if (w0_hit) begin
         case (w0_off[1:0])
            2'd0: begin div_lo_we = 1'b1; div_lo_byte = dwrite_data[7:0]; end
            2'd1: begin div_hi_we = 1'b1; div_hi_byte = dwrite_data[7:0]; end
            2'd2: begin push      = 1'b1; push_byte   = dwrite_data[7:0]; end
            default: begin ctrl_we = 1'b1; ctrl_byte  = dwrite_data[7:0]; end
         endcase
      end
      if (w1_hit) begin
         case (w1_off[1:0])
            2'd0: begin div_lo_we = 1'b1; div_lo_byte = dwrite_data[15:8]; end
            2'd1: begin div_hi_we = 1'b1; div_hi_byte = dwrite_data[15:8]; end
            2'd2: begin push      = 1'b1; push_byte   = dwrite_data[15:8]; end
            default: begin ctrl_we = 1'b1; ctrl_byte  = dwrite_data[15:8]; end
         endcase
      end
   end

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign busy    = (state != IDLE);
   assign pop     = !empty && ((state == IDLE) || ((state == STOP) && (cnt == '0)));
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_byte;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div       <= DEFAULT_DIV;
         ovf       <= 1'b0;
         irq_en    <= 1'b0;
         interrupt <= 1'b0;
      end else begin
         if (div_lo_we) div[7:0]  <= div_lo_byte;
         if (div_hi_we) div[15:8] <= div_hi_byte;
         ovf <= (ovf & ~(ctrl_we & ctrl_byte[3])) | (push & ~push_ok);
         if (ctrl_we) irq_en <= ctrl_byte[7];
         interrupt <= irq_en & empty & ~busy;
      end
   end

   // txd is registered from the state, so the line trails the FSM by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         txd     <= 1'b1;
         cnt     <= '0;
         shreg   <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg <= mem[rd_ptr];
                  cnt   <= div;
                  state <= START;
               end
            end
            START: begin
               if (cnt == '0) begin
                  cnt     <= div;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  cnt   <= div;
                  shreg <= shreg >> 1;
                  if (bit_idx == 3'd7) state <= STOP;
                  else                 bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               if (cnt == '0) begin
                  if (pop) begin
                     shreg <= mem[rd_ptr];
                     cnt   <= div;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
         endcase
         case (state)
            START:   txd <= 1'b0;
            DATA:    txd <= shreg[0];
            default: txd <= 1'b1;
         endcase
      end
   end

   function automatic logic [7:0] reg_byte(input logic [15:0] a);
      logic [15:0] off;
      logic [7:0]  r;
      off = a - BASEADDR;
      r   = '0;
      if (off < 16'd4) begin
         case (off[1:0])
            2'd0:    r = div[7:0];
            2'd1:    r = div[15:8];
            2'd2:    r = '0;
            default: r = {irq_en, 3'b000, ovf, busy, empty, full};
         endcase
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) dread_data <= '0;
      else       dread_data <= {reg_byte(dread_addr + 16'd1), reg_byte(dread_addr)};
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: bytes queued on DATA writes are matched
// against frames decoded from txd, plus register, timing and interrupt checks.
module tb_uart_tx_port;

   localparam logic [15:0] BASE = 16'h0018;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] dwrite_addr = '0;
   logic [15:0] dwrite_data = '0;
   logic [1:0]  dwrite_en = '0;
   logic [15:0] dread_addr = '0;
   logic [15:0] dread_data;
   logic        txd;
   logic        interrupt;

   uart_tx_port #(.BASEADDR(16'h0018), .FIFODEPTH(4), .DEFAULT_DIV(16'd103)) dut (
      .clk(clk), .reset(reset),
      .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
      .dread_addr(dread_addr), .dread_data(dread_data),
      .txd(txd), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [7:0]  sb_q[$];
   int unsigned bit_t = 104;
   logic        mon_en = 1'b1;
   int unsigned frames = 0;
   int unsigned gapless = 0;
   int unsigned start_c = 0;
   int unsigned end_c = 0;
   int unsigned glitch;
   int unsigned bt;
   logic [7:0]  rx;
   logic        v;

   // Frame decoder: every cycle of every bit is sampled to catch timing errors.
   always begin
      @(negedge clk);
      if (mon_en && !reset && txd === 1'b0) begin
         bt      = bit_t;
         glitch  = 0;
         start_c = cyc;
         if (start_c == end_c + 1) gapless++;
         for (int i = 1; i < int'(bt); i++) begin
            @(negedge clk);
            if (txd !== 1'b0) glitch++;
         end
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            v = txd;
            rx[b] = v;
            for (int i = 1; i < int'(bt); i++) begin
               @(negedge clk);
               if (txd !== v) glitch++;
            end
         end
         for (int i = 0; i < int'(bt); i++) begin
            @(negedge clk);
            if (txd !== 1'b1) glitch++;
         end
         end_c = cyc;
         frames++;
         check("frame_timing", glitch, 0);
         check("sb_nonempty", (sb_q.size() != 0), 1);
         if (sb_q.size() != 0) check("rx_byte", rx, sb_q.pop_front());
      end
   end

   logic        log_en = 1'b0;
   logic        log_prev = 1'b1;
   int unsigned edges_q[$];
   always @(negedge clk) begin
      if (log_en && txd !== log_prev) edges_q.push_back(cyc);
      log_prev = txd;
   end

   // Callers are always at a negedge; back-to-back calls give consecutive write edges.
   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
      dwrite_addr = a;
      dwrite_data = d;
      dwrite_en   = en;
      @(negedge clk);
      dwrite_en   = 2'b00;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      dread_addr = a;
      @(negedge clk);
      d = dread_data;
   endtask

   task automatic push_byte(input logic [7:0] b, input logic expect_tx);
      if (expect_tx) sb_q.push_back(b);
      wr(BASE + 16'd2, {8'h00, b}, 2'b01);
   endtask

   task automatic wait_frames(input int unsigned n, input int unsigned budget);
      int unsigned k = 0;
      while (frames < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("frames_done", frames, n);
   endtask

   task automatic wait_txd(input logic val);
      int unsigned k = 0;
      while (txd !== val && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("txd_wait", txd, val);
   endtask

   logic [15:0] r;
   int unsigned f0, g0, irq_c, k, lows;
   int unsigned exp_len [9] = '{4, 4, 4, 8, 8, 8, 8, 8, 8};

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_txd", txd, 1);
      check("rst_irq", interrupt, 0);
      rd(BASE + 16'd3, r); check("rst_status", r, 16'h0002);
      rd(BASE, r);         check("rst_div", r, 16'd103);
      rd(BASE + 16'd2, r); check("rst_data_status", r, 16'h0200);

      // 8'h55 at DIV=3: start bit two cycles after the write edge
      wr(BASE, 16'd3, 2'b11);
      bit_t = 4;
      f0 = frames;
      push_byte(8'h55, 1'b1);
      check("start_lat0", txd, 1);
      @(negedge clk); check("start_lat1", txd, 1);
      @(negedge clk); check("start_lat2", txd, 0);
      rd(BASE + 16'd3, r); check("status_busy", r, 16'h0006);
      wait_frames(f0 + 1, 200);
      rd(BASE + 16'd3, r); check("status_idle", r, 16'h0002);

      // DIV=0 burst: five frames gapless, sixth push overflows
      wr(BASE, 16'd0, 2'b11);
      bit_t = 1;
      f0 = frames;
      g0 = gapless;
      for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1);
      push_byte(8'h06, 1'b0);
      rd(BASE + 16'd3, r); check("status_full_ovf", r, 16'h000D);
      wr(BASE + 16'd3, 16'h0008, 2'b01);
      rd(BASE + 16'd3, r); check("status_ovf_clr", r, 16'h0005);
      wait_frames(f0 + 5, 300);
      check("gapless", gapless - g0, 4);
      rd(BASE + 16'd3, r); check("status_drained", r, 16'h0002);

      // Word write pushes 8'hA5 and enables the interrupt
      wr(BASE, 16'd3, 2'b11);
      bit_t = 4;
      f0 = frames;
      sb_q.push_back(8'hA5);
      wr(BASE + 16'd2, 16'h80A5, 2'b11);
      irq_c = 0;
      k = 0;
      while (irq_c == 0 && k < 200) begin
         @(negedge clk);
         k++;
         if (interrupt === 1'b1) irq_c = cyc;
      end
      check("irq_frames", frames, f0 + 1);
      check("irq_timing", irq_c, end_c + 1);
      rd(BASE + 16'd3, r); check("status_irq_en", r, 16'h0082);
      wr(BASE + 16'd3, 16'h0000, 2'b01);
      check("irq_lag", interrupt, 1);
      @(negedge clk); check("irq_clear", interrupt, 0);

      // DIV 3 -> 7 written during data bit 1
      mon_en = 1'b0;
      log_en = 1'b1;
      wr(BASE + 16'd2, 16'h0055, 2'b01);
      wait_txd(1'b0);
      wait_txd(1'b1);
      wait_txd(1'b0);
      wr(BASE, 16'd7, 2'b01);
      k = 0;
      while (edges_q.size() < 10 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("edge_count", edges_q.size(), 10);
      if (edges_q.size() >= 10)
         for (int i = 0; i < 9; i++)
            check("bit_len", edges_q[i+1] - edges_q[i], exp_len[i]);
      log_en = 1'b0;
      repeat (12) @(negedge clk);
      rd(BASE + 16'd3, r); check("status_after_div", r, 16'h0002);

      // Reset mid-DATA with two bytes still queued
      push_byte(8'h00, 1'b0);
      push_byte(8'h11, 1'b0);
      push_byte(8'h22, 1'b0);
      wait_txd(1'b0);
      repeat (12) @(negedge clk);
      check("pre_reset_txd", txd, 0);
      reset = 1'b1;
      @(negedge clk);
      check("reset_txd", txd, 1);
      check("reset_irq", interrupt, 0);
      reset = 1'b0;
      rd(BASE + 16'd3, r); check("reset_status", r, 16'h0002);
      lows = 0;
      repeat (150) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("no_frames_after_reset", lows, 0);
      rd(16'h0010, r);     check("rd_outside", r, 16'h0000);
      rd(16'h0017, r);     check("rd_straddle_lo", r, 16'h6700);
      rd(BASE + 16'd3, r); check("rd_straddle_hi", r, 16'h0002);
      wr(16'h0014, 16'hFFFF, 2'b11);
      wr(16'h001C, 16'hFFFF, 2'b11);
      rd(BASE, r);         check("wr_outside", r, 16'd103);
      rd(BASE + 16'd3, r); check("wr_outside_status", r, 16'h0002);

      check("sb_left", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
